// File: rtl/vc_input_buffer_pkg.sv
// Shared NoC definitions for the VC input buffer: flit-type encodings and field placement.
package vc_input_buffer_pkg;

    typedef enum logic [2:0] {
        FLIT_HEAD = 3'b000,
        FLIT_BODY = 3'b001,
        FLIT_TAIL = 3'b010
    } flit_type_e;

    localparam int TYPE_LSB_DEFAULT = 55;

    // Occupancy counter width able to represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel circular FIFO; storage is left unreset, only pointers and count clear.
module vc_fifo
    import vc_input_buffer_pkg::*;
#(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [FLIT_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [FLIT_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Parent guarantees rd only when non-empty and wr only when not full or popping.
    always_comb begin
        head_d  = head_q + PTR_W'(rd_en_i);
        tail_d  = tail_q + PTR_W'(wr_en_i);
        count_d = count_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[tail_q] <= wr_data_i;
        end
    end

    assign head_o  = mem_q[head_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port: per-VC FIFOs, round-robin route-computation offer, and granted-VC switch stage.
module vc_input_buffer
    import vc_input_buffer_pkg::*;
#(
    parameter int FLIT_W   = 64,
    parameter int NUM_VC   = 4,
    parameter int DEPTH    = 4,
    parameter int TYPE_LSB = TYPE_LSB_DEFAULT,
    localparam int VC_W    = (NUM_VC > 2) ? $clog2(NUM_VC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic [VC_W-1:0]   data_in_vc,
    output logic [NUM_VC-1:0] vc_status,
    output logic [NUM_VC-1:0] credit_out,
    input  logic [NUM_VC-1:0] vc_grant,
    output logic [FLIT_W-1:0] rc_flit_out,
    output logic              rc_valid,
    output logic [VC_W-1:0]   rc_vc_out,
    output logic [VC_W-1:0]   sa_vc_out,
    output logic              vc_active,
    output logic              cba_request,
    input  logic              cba_grant,
    output logic [FLIT_W-1:0] cbs_flit_out,
    output logic [VC_W-1:0]   cbs_vc_out,
    output logic              cbs_valid,
    output logic              overflow_err
);

    logic [NUM_VC-1:0] full, empty, enq, deq, is_tail;
    logic [FLIT_W-1:0] head [NUM_VC];
    logic [NUM_VC-1:0] granted_q, granted_d;
    logic [NUM_VC-1:0] credit_q;
    logic [VC_W-1:0]   last_q, last_d;
    logic              overflow_q, overflow_d;
    logic [VC_W-1:0]   act_vc, rc_vc;
    logic              act_found, rc_found;
    logic              in_range, drop;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo #(
            .FLIT_W (FLIT_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (enq[v]),
            .wr_data_i (data_in),
            .rd_en_i   (deq[v]),
            .head_o    (head[v]),
            .full_o    (full[v]),
            .empty_o   (empty[v])
        );
        assign is_tail[v] = (head[v][TYPE_LSB +: 3] == FLIT_TAIL);
    end

    // Switch stage serves the lowest-index granted VC that has data.
    always_comb begin
        act_found = 1'b0;
        act_vc    = '0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (granted_q[v] && !empty[v]) begin
                act_found = 1'b1;
                act_vc    = VC_W'(v);
            end
        end
    end

    always_comb begin
        rc_found = 1'b0;
        rc_vc    = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            int idx;
            idx = (int'(last_q) + 1 + i) % NUM_VC;
            if (!rc_found && !empty[idx]) begin
                rc_found = 1'b1;
                rc_vc    = VC_W'(idx);
            end
        end
    end

    assign in_range = ({{(32-VC_W){1'b0}}, data_in_vc} < 32'(NUM_VC));

    // A full VC still accepts when it is popping on the same edge.
    always_comb begin
        deq = '0;
        enq = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            deq[v] = cba_grant && act_found && (act_vc == VC_W'(v));
            enq[v] = data_in_valid && in_range && (data_in_vc == VC_W'(v))
                     && (!full[v] || deq[v]);
        end
    end

    assign drop = data_in_valid && (enq == '0);

    always_comb begin
        granted_d  = vc_grant | (granted_q & ~(deq & is_tail));
        last_d     = (|deq) ? act_vc : last_q;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            granted_q  <= '0;
            credit_q   <= '0;
            last_q     <= VC_W'(NUM_VC - 1);
            overflow_q <= 1'b0;
        end else begin
            granted_q  <= granted_d;
            credit_q   <= deq;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign vc_status    = ~full;
    assign credit_out   = credit_q;
    assign overflow_err = overflow_q;

    assign rc_valid    = rc_found;
    assign rc_vc_out   = rc_vc;
    assign rc_flit_out = rc_found ? head[rc_vc] : '0;

    assign vc_active    = act_found;
    assign cba_request  = act_found;
    assign cbs_valid    = act_found;
    assign sa_vc_out    = act_vc;
    assign cbs_vc_out   = act_vc;
    assign cbs_flit_out = act_found ? head[act_vc] : '0;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed bench for vc_input_buffer with NUM_VC=4, DEPTH=4, FLIT_W=64, type field at [57:55].
module tb_vc_input_buffer;

    localparam logic [2:0] T_HEAD = 3'b000;
    localparam logic [2:0] T_BODY = 3'b001;
    localparam logic [2:0] T_TAIL = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [1:0]  data_in_vc = '0;
    logic [3:0]  vc_status;
    logic [3:0]  credit_out;
    logic [3:0]  vc_grant = '0;
    logic [63:0] rc_flit_out;
    logic        rc_valid;
    logic [1:0]  rc_vc_out;
    logic [1:0]  sa_vc_out;
    logic        vc_active;
    logic        cba_request;
    logic        cba_grant = 1'b0;
    logic [63:0] cbs_flit_out;
    logic [1:0]  cbs_vc_out;
    logic        cbs_valid;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    vc_input_buffer #(.FLIT_W(64), .NUM_VC(4), .DEPTH(4), .TYPE_LSB(55)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_vc    (data_in_vc),
        .vc_status     (vc_status),
        .credit_out    (credit_out),
        .vc_grant      (vc_grant),
        .rc_flit_out   (rc_flit_out),
        .rc_valid      (rc_valid),
        .rc_vc_out     (rc_vc_out),
        .sa_vc_out     (sa_vc_out),
        .vc_active     (vc_active),
        .cba_request   (cba_request),
        .cba_grant     (cba_grant),
        .cbs_flit_out  (cbs_flit_out),
        .cbs_vc_out    (cbs_vc_out),
        .cbs_valid     (cbs_valid),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] mk(input logic [2:0] t, input logic [63:0] p);
        logic [63:0] f;
        f = p;
        f[57:55] = t;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        data_in_valid = 1'b0;
        vc_grant = '0;
        cba_grant = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send(input logic [1:0] vc, input logic [63:0] flit);
        data_in_valid = 1'b1;
        data_in_vc = vc;
        data_in = flit;
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (vc_status !== 4'hF) begin errors++; $display("FAIL reset_vc_status got %h exp f", vc_status); end
        checks++; if ({rc_valid, cbs_valid, cba_request, vc_active, overflow_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 00000", {rc_valid, cbs_valid, cba_request, vc_active, overflow_err}); end
        checks++; if (credit_out !== 4'h0) begin errors++; $display("FAIL reset_credit got %h exp 0", credit_out); end
        checks++; if (rc_flit_out !== 64'h0 || cbs_flit_out !== 64'h0) begin
            errors++; $display("FAIL reset_flits got rc %h cbs %h exp 0", rc_flit_out, cbs_flit_out); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 4; k++) send(2'd2, mk(T_BODY, 64'h100 + 64'(k)));
        checks++; if (vc_status !== 4'b1011) begin errors++; $display("FAIL ovf_full_status got %b exp 1011", vc_status); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow_err); end
        send(2'd2, mk(T_BODY, 64'h1FF));
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_err); end
        checks++; if (vc_status !== 4'b1011) begin errors++; $display("FAIL ovf_status_after got %b exp 1011", vc_status); end
        checks++; if (rc_valid !== 1'b1 || rc_vc_out !== 2'd2 || rc_flit_out !== mk(T_BODY, 64'h100)) begin
            errors++; $display("FAIL ovf_rc got v%b vc%0d %h exp v1 vc2 %h", rc_valid, rc_vc_out, rc_flit_out, mk(T_BODY, 64'h100)); end
        tick();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_err); end
    endtask

    task automatic test_full_bypass();
        do_reset();
        for (int k = 0; k < 4; k++) send(2'd1, mk(T_BODY, 64'h10 + 64'(k)));
        vc_grant = 4'b0010;
        tick();
        vc_grant = 4'b0000;
        checks++; if (cbs_valid !== 1'b1 || cbs_vc_out !== 2'd1 || cbs_flit_out !== mk(T_BODY, 64'h10)) begin
            errors++; $display("FAIL byp_present got v%b vc%0d %h exp v1 vc1 %h", cbs_valid, cbs_vc_out, cbs_flit_out, mk(T_BODY, 64'h10)); end
        cba_grant = 1'b1;
        send(2'd1, mk(T_BODY, 64'h14));
        cba_grant = 1'b0;
        checks++; if (vc_status !== 4'b1101) begin errors++; $display("FAIL byp_count_full got %b exp 1101", vc_status); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL byp_no_ovf got %b exp 0", overflow_err); end
        checks++; if (credit_out !== 4'b0010) begin errors++; $display("FAIL byp_credit got %b exp 0010", credit_out); end
        checks++; if (cbs_flit_out !== mk(T_BODY, 64'h11)) begin errors++; $display("FAIL byp_next_head got %h exp %h", cbs_flit_out, mk(T_BODY, 64'h11)); end
        tick();
        checks++; if (credit_out !== 4'b0000) begin errors++; $display("FAIL byp_credit_end got %b exp 0000", credit_out); end
    endtask

    task automatic test_packet();
        logic [63:0] pkt [4];
        pkt[0] = mk(T_HEAD, 64'hA0);
        pkt[1] = mk(T_BODY, 64'hA1);
        pkt[2] = mk(T_TAIL, 64'hA2);
        pkt[3] = mk(T_HEAD, 64'hB0);
        do_reset();
        for (int k = 0; k < 4; k++) send(2'd0, pkt[k]);
        vc_grant = 4'b0001;
        tick();
        vc_grant = 4'b0000;
        cba_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (cbs_valid !== 1'b1 || cbs_flit_out !== pkt[k]) begin
                errors++; $display("FAIL pkt_flit%0d got v%b %h exp v1 %h", k, cbs_valid, cbs_flit_out, pkt[k]); end
            tick();
            checks++; if (credit_out !== 4'b0001) begin errors++; $display("FAIL pkt_credit%0d got %b exp 0001", k, credit_out); end
        end
        checks++; if (vc_active !== 1'b0 || cba_request !== 1'b0 || cbs_flit_out !== 64'h0) begin
            errors++; $display("FAIL pkt_ungranted got act%b req%b %h exp 0 0 0", vc_active, cba_request, cbs_flit_out); end
        checks++; if (rc_valid !== 1'b1 || rc_flit_out !== pkt[3]) begin
            errors++; $display("FAIL pkt_rc_next got v%b %h exp v1 %h", rc_valid, rc_flit_out, pkt[3]); end
        tick();
        cba_grant = 1'b0;
        checks++; if (credit_out !== 4'b0000) begin errors++; $display("FAIL pkt_no_extra_pop got %b exp 0000", credit_out); end
    endtask

    task automatic test_rc_rr();
        do_reset();
        for (int v = 0; v < 4; v++) send(2'(v), mk(T_TAIL, 64'h20 + 64'(v)));
        vc_grant = 4'hF;
        tick();
        vc_grant = 4'h0;
        cba_grant = 1'b1;
        for (int v = 0; v < 4; v++) begin
            checks++; if (rc_valid !== 1'b1 || rc_vc_out !== 2'(v) || rc_flit_out !== mk(T_TAIL, 64'h20 + 64'(v))) begin
                errors++; $display("FAIL rr_step%0d got v%b vc%0d %h exp vc%0d", v, rc_valid, rc_vc_out, rc_flit_out, v); end
            checks++; if (cbs_vc_out !== 2'(v) || sa_vc_out !== 2'(v)) begin
                errors++; $display("FAIL rr_sa%0d got cbs%0d sa%0d exp %0d", v, cbs_vc_out, sa_vc_out, v); end
            tick();
        end
        cba_grant = 1'b0;
        checks++; if (rc_valid !== 1'b0 || rc_vc_out !== 2'd0 || rc_flit_out !== 64'h0) begin
            errors++; $display("FAIL rr_empty got v%b vc%0d %h exp 0", rc_valid, rc_vc_out, rc_flit_out); end
    endtask

    task automatic test_priority();
        logic [63:0] exp_f [4];
        logic [1:0]  exp_v [4];
        exp_f[0] = mk(T_HEAD, 64'hC0); exp_v[0] = 2'd0;
        exp_f[1] = mk(T_TAIL, 64'hC1); exp_v[1] = 2'd0;
        exp_f[2] = mk(T_HEAD, 64'hD0); exp_v[2] = 2'd2;
        exp_f[3] = mk(T_TAIL, 64'hD1); exp_v[3] = 2'd2;
        do_reset();
        send(2'd2, exp_f[2]);
        send(2'd0, exp_f[0]);
        send(2'd2, exp_f[3]);
        send(2'd0, exp_f[1]);
        vc_grant = 4'b0101;
        tick();
        vc_grant = 4'b0000;
        cba_grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (cbs_valid !== 1'b1 || cbs_vc_out !== exp_v[k] || cbs_flit_out !== exp_f[k]) begin
                errors++; $display("FAIL prio_step%0d got v%b vc%0d %h exp vc%0d %h", k, cbs_valid, cbs_vc_out, cbs_flit_out, exp_v[k], exp_f[k]); end
            tick();
        end
        cba_grant = 1'b0;
        checks++; if (vc_active !== 1'b0 || vc_status !== 4'hF) begin
            errors++; $display("FAIL prio_drained got act%b st%b exp 0 1111", vc_active, vc_status); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(2'd3, mk(T_HEAD, 64'hE0));
        send(2'd3, mk(T_BODY, 64'hE1));
        vc_grant = 4'b1000;
        tick();
        vc_grant = 4'b0000;
        cba_grant = 1'b1;
        tick();
        cba_grant = 1'b0;
        checks++; if (credit_out !== 4'b1000) begin errors++; $display("FAIL mid_credit_pre got %b exp 1000", credit_out); end
        rst = 1'b0;
        #1;
        checks++; if (credit_out !== 4'b0000 || vc_status !== 4'hF) begin
            errors++; $display("FAIL mid_async got cr%b st%b exp 0000 1111", credit_out, vc_status); end
        checks++; if ({rc_valid, cbs_valid, cba_request, vc_active} !== 4'b0 || rc_flit_out !== 64'h0 || cbs_flit_out !== 64'h0) begin
            errors++; $display("FAIL mid_outputs got %b rc %h cbs %h exp 0", {rc_valid, cbs_valid, cba_request, vc_active}, rc_flit_out, cbs_flit_out); end
        tick();
        rst = 1'b1;
        cba_grant = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (credit_out !== 4'b0000 || rc_valid !== 1'b0) begin
                errors++; $display("FAIL mid_post%0d got cr%b rc%b exp 0000 0", k, credit_out, rc_valid); end
        end
        cba_grant = 1'b0;
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_full_bypass();
        test_packet();
        test_rc_rr();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 Parameter FLIT_W, default 64, flit width in bits.
REQ-002 Parameter NUM_VC, default 4, number of virtual channels (2..8).
REQ-003 Parameter DEPTH, default 4, flits per VC FIFO (power of two, >=2).
REQ-004 Parameter TYPE_LSB, default 55, LSB of the 3-bit flit-type field; tail type is 3'b010.
REQ-005 Derived VC_W = max(1, clog2(NUM_VC)); CNT_W = clog2(DEPTH+1).
REQ-006 Port clk  input  1  sole clock, rising edge.
REQ-007 Port rst  input  1  asynchronous, active-low reset.
REQ-008 Port data_in  input  FLIT_W  incoming flit.
REQ-009 Port data_in_valid  input  1  data_in qualifier.
REQ-010 Port data_in_vc  input  VC_W  target VC of data_in.
REQ-011 Port vc_status  output  NUM_VC  bit v = VC v not full.
REQ-012 Port credit_out  output  NUM_VC  one-cycle pulse per dequeued flit, per VC.
REQ-013 Port vc_grant  input  NUM_VC  VC-allocation grant pulses.
REQ-014 Port rc_flit_out / rc_valid / rc_vc_out  output  FLIT_W / 1 / VC_W  head flit offered to route computation.
REQ-015 Port sa_vc_out  output  VC_W  VC currently driving the switch stage.
REQ-016 Port vc_active  output  1  some granted VC is non-empty.
REQ-017 Port cba_request  output  1  crossbar request; cba_grant  input  1  crossbar grant.
REQ-018 Port cbs_flit_out / cbs_vc_out / cbs_valid  output  FLIT_W / VC_W / 1  flit presented to crossbar.
REQ-019 Port overflow_err  output  1  sticky error flag.

Function
REQ-020 Each VC SHALL be a circular FIFO of DEPTH entries with head, tail (clog2(DEPTH) bits, natural wrap) and CNT_W-bit count.
REQ-021 Enqueue v when data_in_valid, data_in_vc==v, and (count<DEPTH or dequeue v same cycle); full+simultaneous dequeue SHALL accept.
REQ-022 Flit to full VC without same-cycle dequeue, or data_in_vc>=NUM_VC: drop flit, set overflow_err, no state change.
REQ-023 vc_status[v] SHALL equal (count_v != DEPTH), combinational from registered count.
REQ-024 granted_v SHALL set on the edge where vc_grant[v]=1.
REQ-025 Active VC = lowest-index v with granted_v and count_v>0; none -> cbs_valid, cba_request, vc_active = 0, cbs_flit_out = 0, sa_vc_out = cbs_vc_out = 0.
REQ-026 cba_request = cbs_valid = vc_active; cbs_flit_out = head of active VC; cbs_vc_out = sa_vc_out = active VC.
REQ-027 Dequeue of active VC occurs on the edge where cba_grant=1 and cba_request=1; zero-latency grant-to-pop.
REQ-028 Dequeue of a tail flit SHALL clear granted_v at the next edge; vc_grant[v] on that edge keeps granted_v set.
REQ-029 credit_out[v] SHALL be a registered pulse, high exactly the cycle after each dequeue of v.
REQ-030 RC selection SHALL be round-robin: first non-empty VC searching from (last_served+1) mod NUM_VC upward with wrap; rc_valid = any VC non-empty; none -> rc_flit_out = 0, rc_vc_out = 0.
REQ-031 last_served SHALL update to cbs_vc_out on each dequeue edge.
REQ-032 Flit-type decode SHALL use bits [TYPE_LSB+2:TYPE_LSB] of the head flit.

Reset
REQ-033 rst low SHALL immediately clear all pointers, counts, granted flags, last_served (to NUM_VC-1), credit_out and overflow_err; FIFO storage is not reset.
REQ-034 After reset: vc_status all ones, every valid/request output 0, all flit outputs 0.
REQ-035 Reset mid-packet SHALL discard all buffered flits without issuing credits.

Structure
REQ-036 Flit-type encodings (head/body/tail) and TYPE_LSB default SHALL live in the shared noc package.
REQ-037 One sub-module vc_fifo (single VC, DEPTH/FLIT_W parametrised) SHALL be instantiated NUM_VC times; arbitration and grant logic stay in the parent.

Verification
REQ-038 Reset, enqueue 4 flits to VC2 (DEPTH=4) -> vc_status[2]=0, 5th flit dropped, overflow_err=1.
REQ-039 VC1 full, vc_grant[1], cba_grant held with new flit same cycle -> flit accepted, count stays 4, credit_out[1] pulses next cycle.
REQ-040 Head/body/tail packet on VC0, granted, cba_grant continuous -> 3 dequeues in 3 cycles, granted_0 low the cycle after tail.
REQ-041 VC0..VC3 each hold one flit, last_served=3 -> rc_vc_out sequence 0,1,2,3 across successive dequeues.
REQ-042 Granted VC0 and VC2 both non-empty -> cbs_vc_out=0 until VC0 tail leaves, then 2.
REQ-043 rst asserted mid-packet -> all outputs zero immediately; no credit_out pulse after release.
